// File: rtl/tank_collision_unit.sv
// Per-frame collision and scoring unit: accumulates object-pair overlap counts
// over a frame and commits thresholded flags, hits and scores at vsync rise.
module tank_collision_unit #(
  parameter int unsigned MIN_OVERLAP  = 2,
  parameter int unsigned HIT_COOLDOWN = 30,
  parameter int unsigned MAX_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_on,
  input  logic       vsync,
  input  logic       tank1_gfx,
  input  logic       tank2_gfx,
  input  logic       missile1_gfx,
  input  logic       missile2_gfx,
  input  logic       playfield_gfx,
  output logic       coll_t1_pf,
  output logic       coll_t2_pf,
  output logic       coll_t1_t2,
  output logic       hit_t1,
  output logic       hit_t2,
  output logic       frame_done,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned CD_W    = 6;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned NPAIR   = 5;

  // Pair indices into the counter array
  localparam int unsigned P_T1_PF = 0;
  localparam int unsigned P_T2_PF = 1;
  localparam int unsigned P_T1_T2 = 2;
  localparam int unsigned P_M2_T1 = 3;
  localparam int unsigned P_M1_T2 = 4;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACCUM     = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 vsync_d;
  logic                 rise_c;
  logic [NPAIR-1:0]     pix_c;
  logic [NPAIR-1:0]     cand_c;
  logic [CNT_W-1:0]     cnt     [NPAIR];
  logic [CNT_W-1:0]     cnt_nxt [NPAIR];
  logic [SUM_W-1:0]     sum_c   [NPAIR];
  logic [CD_W-1:0]      cd1, cd2;
  logic                 commit_c, scoring_c;
  logic                 hit1_c, hit2_c, end_c;
  logic [SCORE_W-1:0]   score1_nxt, score2_nxt;

  assign rise_c = vsync & ~vsync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vsync_d <= 1'b0;
    else        vsync_d <= vsync;
  end

  // Pixel overlaps this cycle; a missile over its own tank is never counted
  always_comb begin
    pix_c = '0;
    if (display_on) begin
      pix_c[P_T1_PF] = tank1_gfx & playfield_gfx;
      pix_c[P_T2_PF] = tank2_gfx & playfield_gfx;
      pix_c[P_T1_T2] = tank1_gfx & tank2_gfx;
      pix_c[P_M2_T1] = missile2_gfx & tank1_gfx;
      pix_c[P_M1_T2] = missile1_gfx & tank2_gfx;
    end
  end

  // Saturating increment; candidates include the pixel of the commit cycle
  always_comb begin
    cand_c = '0;
    for (int i = 0; i < NPAIR; i++) begin
      sum_c[i]   = {1'b0, cnt[i]} + SUM_W'(pix_c[i]);
      cand_c[i]  = (sum_c[i] >= SUM_W'(MIN_OVERLAP));
      cnt_nxt[i] = sum_c[i][CNT_W] ? '1 : sum_c[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPAIR; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NPAIR; i++) begin
        if (state == WAIT_SYNC || rise_c) cnt[i] <= '0;
        else                              cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_SYNC;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SYNC: if (rise_c) state_nxt = ACCUM;
      ACCUM:     if (end_c)  state_nxt = GAME_OVER;
      GAME_OVER: state_nxt = GAME_OVER;
      default:   state_nxt = WAIT_SYNC;
    endcase
  end

  // Commit decode: hits only score while the game is live
  always_comb begin
    commit_c   = rise_c & (state != WAIT_SYNC);
    scoring_c  = commit_c & (state == ACCUM);
    hit1_c     = scoring_c & cand_c[P_M2_T1] & (cd1 == '0);
    hit2_c     = scoring_c & cand_c[P_M1_T2] & (cd2 == '0);
    score1_nxt = score1 + SCORE_W'(hit2_c);
    score2_nxt = score2 + SCORE_W'(hit1_c);
    end_c      = scoring_c & ((score1_nxt == SCORE_W'(MAX_SCORE)) |
                              (score2_nxt == SCORE_W'(MAX_SCORE)));
  end

  // Hit cooldowns count frames, not cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cd1 <= '0;
      cd2 <= '0;
    end else begin
      if (hit1_c)                       cd1 <= CD_W'(HIT_COOLDOWN);
      else if (scoring_c && cd1 != '0)  cd1 <= cd1 - CD_W'(1);
      if (hit2_c)                       cd2 <= CD_W'(HIT_COOLDOWN);
      else if (scoring_c && cd2 != '0)  cd2 <= cd2 - CD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_t1_pf <= 1'b0;
      coll_t2_pf <= 1'b0;
      coll_t1_t2 <= 1'b0;
      hit_t1     <= 1'b0;
      hit_t2     <= 1'b0;
      frame_done <= 1'b0;
      score1     <= '0;
      score2     <= '0;
      game_over  <= 1'b0;
      winner     <= '0;
    end else begin
      frame_done <= commit_c;
      if (commit_c) begin
        coll_t1_pf <= cand_c[P_T1_PF];
        coll_t2_pf <= cand_c[P_T2_PF];
        coll_t1_t2 <= cand_c[P_T1_T2];
        hit_t1     <= hit1_c;
        hit_t2     <= hit2_c;
        score1     <= score1_nxt;
        score2     <= score2_nxt;
      end
      if (end_c) begin
        game_over <= 1'b1;
        winner    <= {score2_nxt == SCORE_W'(MAX_SCORE),
                      score1_nxt == SCORE_W'(MAX_SCORE)};
      end
    end
  end

endmodule

// File: tb/tb_tank_collision_unit.sv
// Randomized and directed bench for tank_collision_unit against a frame-level
// reference model built from unbounded per-frame overlap counts.
module tb_tank_collision_unit;

  localparam int unsigned MIN_OV = 2;
  localparam int unsigned COOL   = 3;
  localparam int unsigned MAXS   = 9;

  localparam logic [4:0] G_NONE  = 5'b00000;
  localparam logic [4:0] G_T1PF  = 5'b10001;  // {pf, m2, m1, t2, t1}
  localparam logic [4:0] G_M2T1  = 5'b01001;
  localparam logic [4:0] G_M1T2  = 5'b00110;
  localparam logic [4:0] G_T1T2  = 5'b00011;
  localparam logic [4:0] G_BOTH  = 5'b01111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       display_on = 1'b0, vsync = 1'b0;
  logic       tank1_gfx = 1'b0, tank2_gfx = 1'b0;
  logic       missile1_gfx = 1'b0, missile2_gfx = 1'b0, playfield_gfx = 1'b0;
  logic       coll_t1_pf, coll_t2_pf, coll_t1_t2, hit_t1, hit_t2, frame_done;
  logic [3:0] score1, score2;
  logic       game_over;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int         m_cnt [5];
  int         m_cd1, m_cd2, m_s1, m_s2;
  bit         m_armed, m_over, m_vs_prev;
  logic [2:0] e_coll;
  logic [1:0] e_hit;
  logic       e_fd, e_go;
  logic [1:0] e_win;

  tank_collision_unit #(
    .MIN_OVERLAP (MIN_OV),
    .HIT_COOLDOWN(COOL),
    .MAX_SCORE   (MAXS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .display_on   (display_on),
    .vsync        (vsync),
    .tank1_gfx    (tank1_gfx),
    .tank2_gfx    (tank2_gfx),
    .missile1_gfx (missile1_gfx),
    .missile2_gfx (missile2_gfx),
    .playfield_gfx(playfield_gfx),
    .coll_t1_pf   (coll_t1_pf),
    .coll_t2_pf   (coll_t2_pf),
    .coll_t1_t2   (coll_t1_t2),
    .hit_t1       (hit_t1),
    .hit_t2       (hit_t2),
    .frame_done   (frame_done),
    .score1       (score1),
    .score2       (score2),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [16:0] act_vec();
    return {coll_t1_pf, coll_t2_pf, coll_t1_t2, hit_t1, hit_t2, frame_done,
            score1, score2, game_over, winner};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {e_coll, e_hit, e_fd, 4'(m_s1), 4'(m_s2), e_go, e_win};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) m_cnt[k] = 0;
    m_cd1 = 0; m_cd2 = 0; m_s1 = 0; m_s2 = 0;
    m_armed = 0; m_over = 0; m_vs_prev = 0;
    e_coll = '0; e_hit = '0; e_fd = 0; e_go = 0; e_win = '0;
  endtask

  // End-of-frame bookkeeping: thresholds, hits, cooldown in frames, game end
  task automatic model_commit();
    bit h1, h2;
    e_coll = {m_cnt[0] >= int'(MIN_OV), m_cnt[1] >= int'(MIN_OV), m_cnt[2] >= int'(MIN_OV)};
    e_fd = 1;
    h1 = 0; h2 = 0;
    if (!m_over) begin
      h1 = (m_cnt[3] >= int'(MIN_OV)) && (m_cd1 == 0);
      h2 = (m_cnt[4] >= int'(MIN_OV)) && (m_cd2 == 0);
      if (h1) begin m_s2++; m_cd1 = COOL; end else if (m_cd1 > 0) m_cd1--;
      if (h2) begin m_s1++; m_cd2 = COOL; end else if (m_cd2 > 0) m_cd2--;
      if (m_s1 == int'(MAXS) || m_s2 == int'(MAXS)) begin
        m_over = 1; e_go = 1;
        e_win = {m_s2 == int'(MAXS), m_s1 == int'(MAXS)};
      end
    end
    e_hit = {h1, h2};
    for (int k = 0; k < 5; k++) m_cnt[k] = 0;
  endtask

  task automatic model_edge(input logic disp, input logic vs, input logic [4:0] g);
    bit rise;
    rise = vs && !m_vs_prev;
    m_vs_prev = vs;
    e_fd = 0;
    if (!m_armed) begin
      if (rise) m_armed = 1;
    end else begin
      if (disp) begin
        m_cnt[0] += int'(g[0] & g[4]);
        m_cnt[1] += int'(g[1] & g[4]);
        m_cnt[2] += int'(g[0] & g[1]);
        m_cnt[3] += int'(g[3] & g[0]);
        m_cnt[4] += int'(g[2] & g[1]);
      end
      if (rise) model_commit();
    end
  endtask

  task automatic step(input logic disp, input logic vs, input logic [4:0] g);
    @(negedge clk);
    display_on = disp;
    vsync = vs;
    {playfield_gfx, missile2_gfx, missile1_gfx, tank2_gfx, tank1_gfx} = g;
    model_edge(disp, vs, g);
    @(posedge clk);
    #1;
    check("outs", 32'(act_vec()), 32'(exp_vec()));
  endtask

  function automatic logic [4:0] rand_gfx();
    logic [4:0] g;
    for (int b = 0; b < 5; b++) g[b] = ($urandom_range(0, 3) == 0);
    return g;
  endfunction

  task automatic frame(input int len, input logic [4:0] g, input bit rnd);
    int nh, nl;
    for (int i = 0; i < len; i++) begin
      if (rnd) step($urandom_range(0, 7) != 0, 1'b0, rand_gfx());
      else     step(1'b1, 1'b0, g);
    end
    nh = rnd ? int'($urandom_range(1, 4)) : 2;
    nl = rnd ? int'($urandom_range(1, 3)) : 2;
    for (int i = 0; i < nh; i++) begin
      if (rnd) step($urandom_range(0, 1) != 0, 1'b1, rand_gfx());
      else     step(1'b0, 1'b1, G_NONE);
    end
    for (int i = 0; i < nl; i++) step(1'b0, 1'b0, G_NONE);
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    display_on = 1'b0; vsync = 1'b0;
    {playfield_gfx, missile2_gfx, missile1_gfx, tank2_gfx, tank1_gfx} = G_NONE;
    #1;
    model_reset();
    check("async_reset", 32'(act_vec()), 32'(exp_vec()));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_outs", 32'(act_vec()), 32'(exp_vec()));
    @(negedge clk);
    reset = 1'b1;

    // First vsync only arms; second commits the wall hit
    frame(10, G_T1PF, 0);
    frame(10, G_T1PF, 0);
    check("t1pf_flag", 32'(coll_t1_pf), 32'(1));
    check("t1pf_others", 32'({coll_t2_pf, coll_t1_t2, hit_t1, hit_t2}), 32'(0));

    frame(1, G_M2T1, 0);
    check("hit_1px", 32'({hit_t1, score2}), 32'({1'b0, 4'd0}));
    frame(2, G_M2T1, 0);
    check("hit_2px", 32'({hit_t1, score2}), 32'({1'b1, 4'd1}));

    // Long overlap must saturate rather than wrap
    frame(300, G_T1T2, 0);
    check("sat_t1t2", 32'(coll_t1_t2), 32'(1));
    frame(10, G_NONE, 0);
    check("clear_t1t2", 32'(coll_t1_t2), 32'(0));

    // Cooldown of 3 frames: hits land on frames 1, 5, 9
    apply_reset();
    frame(5, G_M2T1, 0);
    for (int f = 1; f <= 9; f++) begin
      frame(5, G_M2T1, 0);
      check("cool_hit", 32'(hit_t1), 32'((f % 4) == 1));
      check("cool_score", 32'(score2), 32'((f + 3) / 4));
    end

    // Simultaneous hits every scoring frame end in a tie
    apply_reset();
    frame(3, G_BOTH, 0);
    for (int f = 0; f < 60 && !m_over; f++) frame(3, G_BOTH, 0);
    check("tie_state", 32'({game_over, winner, score1, score2}), 32'({1'b1, 2'b11, 4'd9, 4'd9}));
    for (int f = 0; f < 4; f++) begin
      frame(3, G_BOTH, 0);
      check("over_frozen", 32'({hit_t1, hit_t2, score1, score2}), 32'({2'b00, 4'd9, 4'd9}));
    end

    // Mid-frame reset with a live score discards the next frame
    apply_reset();
    frame(5, G_M1T2, 0);
    for (int f = 0; f < 40 && m_s1 < 4; f++) frame(5, G_M1T2, 0);
    check("pre_reset_s1", 32'(score1), 32'(4));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, G_M1T2);
    apply_reset();
    check("rst_score1", 32'(score1), 32'(0));
    frame(10, G_T1PF, 0);
    check("rst_no_commit", 32'(coll_t1_pf), 32'(0));

    // Random play with occasional mid-game resets
    apply_reset();
    for (int f = 0; f < 300; f++) begin
      frame(int'($urandom_range(4, 50)), G_NONE, 1);
      if ($urandom_range(0, 59) == 0) apply_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
